fetch_stage: RTL and testbench

- Instruction fetch stage and IF/ID pipeline register of the MIPS32 core; sits directly upstream of the main control decoder.
- Holds the PC and issues word fetches to instruction memory over a req/valid handshake.
- Latches returned instructions into IF/ID and drives the 6-bit opcode field to the control decoder.
- Honours hazard stalls and branch/jump redirects, discarding wrong-path instructions.

---
 rtl/fetch_stage.sv | 127 ++++++++++++
 tb/tb_fetch_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// MIPS32 instruction fetch stage: PC, req/valid fetch handshake and the IF/ID register.
// A taken redirect discards wrong-path data; an in-flight request is drained first.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic [5:0]  if_id_opcode
);

    // state | meaning
    // FETCH | request at req_addr outstanding, responses go to IF/ID (or hold when stalled)
    // HOLD  | one response parked in the hold buffer, no request issued
    // DRAIN | outstanding request is wrong-path; wait for it, then fetch target
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e      state_q;
    logic [31:0] req_addr_q;
    logic [31:0] target_q;
    logic [31:0] hold_instr_q;
    logic [31:0] hold_pc4_q;
    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] pc4_q;

    logic [31:0] redir_pc;
    logic [31:0] req_addr_inc;

    assign redir_pc     = redirect_pc & ~32'h0000_0003;
    assign req_addr_inc = req_addr_q + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FETCH;
            req_addr_q   <= RESET_PC;
            target_q     <= '0;
            hold_instr_q <= '0;
            hold_pc4_q   <= '0;
            valid_q      <= 1'b0;
            instr_q      <= '0;
            pc4_q        <= '0;
        end else if (redirect_valid) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            case (state_q)
                ST_FETCH: begin
                    if (imem_valid) begin
                        req_addr_q <= redir_pc;
                    end else begin
                        target_q <= redir_pc;
                        state_q  <= ST_DRAIN;
                    end
                end
                ST_HOLD: begin
                    req_addr_q <= redir_pc;
                    state_q    <= ST_FETCH;
                end
                default: begin
                    // newest redirect wins even if the drain completes this cycle
                    target_q <= redir_pc;
                    if (imem_valid) begin
                        req_addr_q <= redir_pc;
                        state_q    <= ST_FETCH;
                    end
                end
            endcase
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (imem_valid) begin
                        req_addr_q <= req_addr_inc;
                        if (stall) begin
                            hold_instr_q <= imem_rdata;
                            hold_pc4_q   <= req_addr_inc;
                            state_q      <= ST_HOLD;
                        end else begin
                            valid_q <= 1'b1;
                            instr_q <= imem_rdata;
                            pc4_q   <= req_addr_inc;
                        end
                    end else if (!stall) begin
                        valid_q <= 1'b0;
                        instr_q <= '0;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        valid_q <= 1'b1;
                        instr_q <= hold_instr_q;
                        pc4_q   <= hold_pc4_q;
                        state_q <= ST_FETCH;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    instr_q <= '0;
                    if (imem_valid) begin
                        req_addr_q <= target_q;
                        state_q    <= ST_FETCH;
                    end
                end
            endcase
        end
    end

    assign imem_req     = (state_q != ST_HOLD);
    assign imem_addr    = req_addr_q;
    assign if_id_valid  = valid_q;
    assign if_id_instr  = instr_q;
    assign if_id_pc4    = pc4_q;
    assign if_id_opcode = instr_q[31:26];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: variable-latency memory, queue-based fetch model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic [5:0]  if_id_opcode;

    int checks = 0;
    int errors = 0;
    int lat    = 0;
    int cnt;

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
        .if_id_pc4(if_id_pc4), .if_id_opcode(if_id_opcode)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[7:2], a[27:2]} ^ 32'h8000_1234;
    endfunction

    // memory: answers a request after lat wait cycles, reset together with the core
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= 0;
        else if (imem_req && !imem_valid) cnt <= cnt + 1;
        else cnt <= 0;
    end

    always_comb begin
        imem_valid = imem_req && (cnt >= lat);
        imem_rdata = imem_valid ? word(imem_addr) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ent_t;

    logic [31:0] m_pc    = RST_PC;
    logic [31:0] m_tgt   = '0;
    logic        m_poison = 1'b0;
    ent_t        m_buf[$];
    logic        m_valid = 1'b0;
    logic [31:0] m_instr = '0;
    logic [31:0] m_pc4   = '0;

    // model: m_buf holds parked responses, m_poison marks an outstanding wrong-path request
    initial begin
        logic        v;
        logic [31:0] d;
        logic [31:0] r;
        ent_t        e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("imem_req",     {31'd0, imem_req},     {31'd0, m_buf.size() == 0});
                chk("imem_addr",    imem_addr,             m_pc);
                chk("if_id_valid",  {31'd0, if_id_valid},  {31'd0, m_valid});
                chk("if_id_instr",  if_id_instr,           m_instr);
                chk("if_id_pc4",    if_id_pc4,             m_pc4);
                chk("if_id_opcode", {26'd0, if_id_opcode}, {26'd0, m_instr[31:26]});
            end else begin
                chk("rst_addr",   imem_addr,             RST_PC);
                chk("rst_valid",  {31'd0, if_id_valid},  32'd0);
                chk("rst_instr",  if_id_instr,           32'd0);
                chk("rst_pc4",    if_id_pc4,             32'd0);
            end
            #4;
            if (!rst_n) begin
                m_pc = RST_PC; m_tgt = '0; m_poison = 1'b0; m_buf.delete();
                m_valid = 1'b0; m_instr = '0; m_pc4 = '0;
            end else begin
                v = imem_valid;
                d = imem_rdata;
                r = {redirect_pc[31:2], 2'b00};
                if (redirect_valid) begin
                    m_valid = 1'b0; m_instr = '0;
                    if (m_poison) begin
                        m_tgt = r;
                        if (v) begin m_pc = r; m_poison = 1'b0; end
                    end else if (m_buf.size() != 0) begin
                        m_buf.delete();
                        m_pc = r;
                    end else if (v) begin
                        m_pc = r;
                    end else begin
                        m_tgt = r; m_poison = 1'b1;
                    end
                end else if (m_poison) begin
                    m_valid = 1'b0; m_instr = '0;
                    if (v) begin m_pc = m_tgt; m_poison = 1'b0; end
                end else if (m_buf.size() != 0) begin
                    if (!stall) begin
                        e = m_buf.pop_front();
                        m_valid = 1'b1; m_instr = e.instr; m_pc4 = e.pc4;
                    end
                end else if (v) begin
                    e.instr = d; e.pc4 = m_pc + 32'd4;
                    m_pc = m_pc + 32'd4;
                    if (stall) m_buf.push_back(e);
                    else begin m_valid = 1'b1; m_instr = e.instr; m_pc4 = e.pc4; end
                end else if (!stall) begin
                    m_valid = 1'b0; m_instr = '0;
                end
            end
        end
    end

    task automatic lit_ifid(input string name, input logic vld, input logic [31:0] ins, input logic [31:0] pc4);
        chk({name, "_valid"}, {31'd0, if_id_valid}, {31'd0, vld});
        chk({name, "_instr"}, if_id_instr, ins);
        if (vld) chk({name, "_pc4"}, if_id_pc4, pc4);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; lat = 0;
        @(negedge clk);
        @(negedge clk);
        lit_ifid("reset", 1'b0, 32'h0, 32'h0);
        chk("reset_pc4", if_id_pc4, 32'h0);
        chk("reset_addr", imem_addr, 32'h0);
        #2 rst_n = 1'b1;

        @(negedge clk); lit_ifid("seq0", 1'b1, 32'h8000_1234, 32'h4);
        chk("seq0_opcode", {26'd0, if_id_opcode}, 32'h20);
        @(negedge clk); lit_ifid("seq4", 1'b1, 32'h8400_1235, 32'h8);
        @(negedge clk); lit_ifid("seq8", 1'b1, 32'h8800_1236, 32'hC);
        chk("seq8_addr", imem_addr, 32'hC);
        stall = 1'b1;
        @(negedge clk); lit_ifid("stall1", 1'b1, 32'h8800_1236, 32'hC);
        chk("stall1_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk); lit_ifid("stall2", 1'b1, 32'h8800_1236, 32'hC);
        chk("stall2_req", {31'd0, imem_req}, 32'd0);
        stall = 1'b0;
        @(negedge clk); lit_ifid("rel12", 1'b1, 32'h8C00_1237, 32'h10);
        @(negedge clk); lit_ifid("rel16", 1'b1, 32'h9000_1230, 32'h14);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        @(negedge clk); redirect_valid = 1'b0;
        lit_ifid("redir_bubble", 1'b0, 32'h0, 32'h0);
        chk("redir_addr", imem_addr, 32'h100);
        @(negedge clk); lit_ifid("redir_100", 1'b1, 32'h8000_1274, 32'h104);

        lat = 3; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        @(negedge clk); redirect_valid = 1'b0;
        chk("drain_addr1", imem_addr, 32'h104);
        @(negedge clk); chk("drain_addr2", imem_addr, 32'h104);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
        @(negedge clk); redirect_valid = 1'b0;
        chk("drain_addr3", imem_addr, 32'h104);
        lit_ifid("drain_bubble", 1'b0, 32'h0, 32'h0);
        @(negedge clk); chk("drain_target", imem_addr, 32'h300);
        lat = 0;
        @(negedge clk); lit_ifid("after_drain", 1'b1, 32'h8000_12F4, 32'h304);

        stall = 1'b1;
        @(negedge clk); chk("hold_req", {31'd0, imem_req}, 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0400;
        @(negedge clk); redirect_valid = 1'b0; stall = 1'b0;
        lit_ifid("hold_redir", 1'b0, 32'h0, 32'h0);
        chk("hold_redir_addr", imem_addr, 32'h400);
        @(negedge clk); lit_ifid("after_hold", 1'b1, 32'h8000_1334, 32'h404);

        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk); redirect_valid = 1'b0;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        @(negedge clk); lit_ifid("wrap", 1'b1, 32'h7FFF_EDCB, 32'h0);
        chk("wrap_pc4", if_id_pc4, 32'h0);
        chk("wrap_opcode", {26'd0, if_id_opcode}, 32'h1F);
        chk("wrap_next", imem_addr, 32'h0);

        @(negedge clk); #2 rst_n = 1'b0;
        #1 lit_ifid("midrst", 1'b0, 32'h0, 32'h0);
        chk("midrst_pc4", if_id_pc4, 32'h0);
        chk("midrst_addr", imem_addr, RST_PC);
        @(negedge clk); #2 rst_n = 1'b1;
        @(negedge clk); lit_ifid("postrst", 1'b1, 32'h8000_1234, 32'h4);

        for (int i = 0; i < 450; i++) begin
            @(negedge clk);
            lat            = (i / 50) % 3;
            stall          = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = $urandom;
        end
        @(negedge clk);
        stall = 1'b0; redirect_valid = 1'b0;
        repeat (6) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
